// File: rtl/seg7_capture.sv
// seg7_capture: recovers the hex nibble shown on a 7-segment bus.
// Latency: a pattern held from edge N is delivered after edge N+2+STABLE_CYCLES.
// Backpressure: digit held until digit_ready; a newer digit overwrites and sets overflow.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   seg_in[6:0]     - segment bus, bit0 = a ... bit6 = g
//   digit_ready     - consumer accepts digit while digit_valid is high
//   digit[3:0]      - decoded nibble
//   digit_valid     - digit holds an undelivered value
//   invalid_pulse   - one-cycle pulse when a stable pattern fails to decode
//   err_count[7:0]  - saturating count of undecodable patterns
//   overflow        - sticky, set when an undelivered digit is overwritten
//
// Build option: define SEG7_CAPTURE_ACTIVE_LOW_EN for common-anode buses
// (seg_in inverted ahead of the synchronizer; an all-ones bus is blank).

module seg7_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       digit_ready,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       invalid_pulse,
    output logic [7:0] err_count,
    output logic       overflow
);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);

    // Returns {decodable, nibble}; blank and unknown patterns report not decodable.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'b0;
        case (p)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    // Polarity is normalised before the synchronizer so everything
    // downstream (reset value 0 = blank included) is active-high.
    logic [6:0] seg_pol;
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
    assign seg_pol = ~seg_in;
`else
    assign seg_pol = seg_in;
`endif

    logic [6:0] sync1_q, seg_s_q, seg_prev_q;
    logic [7:0] stab_cnt_q, stab_cnt_d;
    state_t     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       digit_valid_q, digit_valid_d;
    logic       invalid_pulse_q, invalid_pulse_d;
    logic [7:0] err_count_q, err_count_d;
    logic       overflow_q, overflow_d;

    logic       same;
    logic       accept;
    logic [4:0] dec;
    logic       load;
    logic       bad;

    assign same = (seg_s_q == seg_prev_q);

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (!same) begin
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q < STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    // Accept happens only from SETTLE, so a held pattern is taken once;
    // LOCKED waits for any change before counting starts again.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            SETTLE: begin
                if (same && (stab_cnt_q == ACCEPT_AT)) begin
                    accept  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!same) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    assign dec  = decode(seg_s_q);
    assign load = accept && dec[4];
    assign bad  = accept && (seg_s_q != 7'h00) && !dec[4];

    always_comb begin
        digit_d         = digit_q;
        digit_valid_d   = digit_valid_q;
        overflow_d      = overflow_q;
        err_count_d     = err_count_q;
        invalid_pulse_d = bad;
        if (digit_valid_q && digit_ready) begin
            digit_valid_d = 1'b0;
        end
        // A load wins over a completing handshake; it only counts as an
        // overwrite when the old digit was not taken this cycle.
        if (load) begin
            digit_d       = dec[3:0];
            digit_valid_d = 1'b1;
            if (digit_valid_q && !digit_ready) begin
                overflow_d = 1'b1;
            end
        end
        if (bad && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 7'h00;
            seg_s_q         <= 7'h00;
            seg_prev_q      <= 7'h00;
            stab_cnt_q      <= 8'd0;
            state_q         <= SETTLE;
            digit_q         <= 4'h0;
            digit_valid_q   <= 1'b0;
            invalid_pulse_q <= 1'b0;
            err_count_q     <= 8'd0;
            overflow_q      <= 1'b0;
        end else begin
            sync1_q         <= seg_pol;
            seg_s_q         <= sync1_q;
            seg_prev_q      <= seg_s_q;
            stab_cnt_q      <= stab_cnt_d;
            state_q         <= state_d;
            digit_q         <= digit_d;
            digit_valid_q   <= digit_valid_d;
            invalid_pulse_q <= invalid_pulse_d;
            err_count_q     <= err_count_d;
            overflow_q      <= overflow_d;
        end
    end

    assign digit         = digit_q;
    assign digit_valid   = digit_valid_q;
    assign invalid_pulse = invalid_pulse_q;
    assign err_count     = err_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized and directed bench for seg7_capture.
// Reference model tracks runs of identical input samples at the pattern level.
// Inputs change 1 time unit after a rising edge; outputs are checked on the falling edge.

module tb_seg7_capture;

    localparam int S = 16;

    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in;
    logic       digit_ready = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       invalid_pulse;
    logic [7:0] err_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .digit_ready   (digit_ready),
        .digit         (digit),
        .digit_valid   (digit_valid),
        .invalid_pulse (invalid_pulse),
        .err_count     (err_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Logical pattern <-> bus value (inversion is its own inverse).
    function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (TBL[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run of identical samples that reaches S+1 samples is accepted, and
    // its effect is visible two edges later. Reset behaves like a fresh
    // run of blank three samples long.
    int         m_run_len;
    logic [6:0] m_run_val;
    logic       p0_v, p1_v, ev_v, pre_valid;
    logic [6:0] p0_p, p1_p, ev_p, m_s;
    int         m_idx;
    logic [3:0] exp_digit;
    logic       exp_valid, exp_inv, exp_ovf;
    int         exp_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run_val = 7'h00;
            m_run_len = 3;
            p0_v = 1'b0; p1_v = 1'b0; p0_p = 7'h00; p1_p = 7'h00;
            exp_digit = 4'h0; exp_valid = 1'b0; exp_inv = 1'b0;
            exp_ovf = 1'b0; exp_err = 0;
        end else begin
            ev_v = p1_v; ev_p = p1_p;
            p1_v = p0_v; p1_p = p0_p;
            m_s = enc(seg_in);
            if (m_s == m_run_val) begin
                if (m_run_len < 1000) m_run_len++;
            end else begin
                m_run_val = m_s;
                m_run_len = 1;
            end
            p0_v = (m_run_len == S + 1);
            p0_p = m_run_val;

            pre_valid = exp_valid;
            exp_inv = 1'b0;
            if (exp_valid && digit_ready) exp_valid = 1'b0;
            if (ev_v && ev_p != 7'h00) begin
                m_idx = lookup(ev_p);
                if (m_idx >= 0) begin
                    if (pre_valid && !digit_ready) exp_ovf = 1'b1;
                    exp_digit = 4'(m_idx);
                    exp_valid = 1'b1;
                end else begin
                    exp_inv = 1'b1;
                    if (exp_err < 255) exp_err++;
                end
            end
        end
    end

    // ---------------- per-cycle compare and observers ----------------
    int deliv_q[$];
    int inv_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("digit_valid", int'(digit_valid), int'(exp_valid));
            cmp("digit", int'(digit), int'(exp_digit));
            cmp("invalid_pulse", int'(invalid_pulse), int'(exp_inv));
            cmp("err_count", int'(err_count), exp_err);
            cmp("overflow", int'(overflow), int'(exp_ovf));
            if (digit_valid && digit_ready) deliv_q.push_back(int'(digit));
            if (invalid_pulse) inv_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = enc(p);
        step(n);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        cmp({tag, "_rst_digit"}, int'(digit), 0);
        cmp({tag, "_rst_valid"}, int'(digit_valid), 0);
        cmp({tag, "_rst_inv"}, int'(invalid_pulse), 0);
        cmp({tag, "_rst_err"}, int'(err_count), 0);
        cmp({tag, "_rst_ovf"}, int'(overflow), 0);
        seg_in = enc(7'h00);
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    int lat;

    initial begin
        seg_in = enc(7'h00);
        step(3);
        rst_n = 1'b1;

        // Latency: 0x06 with ready high
        do_reset("t1");
        hold(7'h00, 5);
        digit_ready = 1'b1;
        seg_in = enc(7'h06);
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (digit_valid) break;
        end
        cmp("t1_latency", lat, 18);
        cmp("t1_digit", int'(digit), 1);
        step(1);
        cmp("t1_clear", int'(digit_valid), 0);

        // Glitch rejected
        do_reset("t2");
        digit_ready = 1'b1;
        deliv_q.delete();
        hold(7'h5B, 10);
        hold(7'h4F, 30);
        cmp("t2_ndeliv", deliv_q.size(), 1);
        if (deliv_q.size() > 0) cmp("t2_digit", deliv_q[0], 3);
        cmp("t2_err", int'(err_count), 0);

        // Invalid patterns and saturation
        do_reset("t3");
        inv_cnt = 0;
        hold(7'h55, 30);
        cmp("t3_pulses", inv_cnt, 1);
        cmp("t3_err1", int'(err_count), 1);
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 7'h01 : 7'h55, 20);
        cmp("t3_err_sat", int'(err_count), 255);
        cmp("t3_model_err", exp_err, 255);

        // Backpressure / overwrite
        do_reset("t4");
        digit_ready = 1'b0;
        hold(7'h3F, 20);
        hold(7'h7F, 20);
        cmp("t4_digit", int'(digit), 8);
        cmp("t4_ovf", int'(overflow), 1);
        cmp("t4_valid", int'(digit_valid), 1);
        digit_ready = 1'b1;
        step(1);
        cmp("t4_valid_drop", int'(digit_valid), 0);
        cmp("t4_ovf_sticky", int'(overflow), 1);

        // Same digit re-accepted after blank
        do_reset("t5");
        digit_ready = 1'b1;
        deliv_q.delete();
        hold(7'h6D, 20);
        hold(7'h00, 20);
        hold(7'h6D, 20);
        cmp("t5_ndeliv", deliv_q.size(), 2);
        if (deliv_q.size() == 2) begin
            cmp("t5_d0", deliv_q[0], 5);
            cmp("t5_d1", deliv_q[1], 5);
        end
        cmp("t5_err", int'(err_count), 0);

        // Reset mid-settle and with a pending digit
        digit_ready = 1'b0;
        hold(7'h3F, 5);
        do_reset("t6a");
        hold(7'h55, 20);
        hold(7'h3F, 20);
        cmp("t6_pending", int'(digit_valid), 1);
        do_reset("t6b");
        hold(7'h00, 5);

        // Bus polarity
        do_reset("t7");
        digit_ready = 1'b1;
        deliv_q.delete();
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
        seg_in = 7'h40;
        step(20);
        seg_in = 7'h00;
        step(20);
        seg_in = 7'h7F;
        step(20);
        cmp("t7_ndeliv", deliv_q.size(), 2);
        if (deliv_q.size() == 2) begin
            cmp("t7_d0", deliv_q[0], 0);
            cmp("t7_d1", deliv_q[1], 8);
        end
`else
        seg_in = 7'h7F;
        step(20);
        seg_in = 7'h40;
        step(20);
        cmp("t7_ndeliv", deliv_q.size(), 1);
        if (deliv_q.size() == 1) cmp("t7_d0", deliv_q[0], 8);
        cmp("t7_err", int'(err_count), 1);
`endif

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            logic [6:0] p;
            int sel, n;
            sel = $urandom_range(0, 9);
            if (sel < 6)      p = TBL[$urandom_range(0, 15)];
            else if (sel < 8) p = 7'h00;
            else              p = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 25);
            seg_in = enc(p);
            for (int c = 0; c < n; c++) begin
                digit_ready = ($urandom_range(0, 3) != 0);
                step(1);
            end
            if ($urandom_range(0, 39) == 0) do_reset("rnd");
        end

        digit_ready = 1'b1;
        step(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
